// File: rtl/topk_select_if.sv
// Candidate-in / ranked-result-out handshake bundle for topk_select.
// The master side feeds candidates and consumes results; the slave side is the selector.
interface topk_select_if #(
    parameter int K  = 8,
    parameter int DW = 16,
    parameter int IW = 12
) ();
    localparam int RW = $clog2(K);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_dist;
    logic [IW-1:0] in_idx;
    logic          in_last;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_dist;
    logic [IW-1:0] out_idx;
    logic [RW-1:0] out_rank;
    logic          out_last;

    modport master (
        output in_valid, in_dist, in_idx, in_last, out_ready,
        input  in_ready, out_valid, out_dist, out_idx, out_rank, out_last
    );

    modport slave (
        input  in_valid, in_dist, in_idx, in_last, out_ready,
        output in_ready, out_valid, out_dist, out_idx, out_rank, out_last
    );
endinterface

// File: rtl/topk_select.sv
// Streaming top-K nearest selector: keeps the K smallest distances of a query in a
// sorted slot array, then drains them best-first with rank and last markers.
module topk_select #(
    parameter int K  = 8,
    parameter int DW = 16,
    parameter int IW = 12
) (
    input  logic         clk,
    input  logic         rstn,
    topk_select_if.slave io
);
    localparam int RW = $clog2(K);
    localparam int NW = $clog2(K + 1);

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t        state;
    logic [K-1:0]  sv;
    logic [DW-1:0] sd [K];
    logic [IW-1:0] si [K];
    logic [NW-1:0] n;
    logic [RW-1:0] dcnt;
    logic          rdy_q;
    logic          vld_q;

    logic [K-1:0]  le;
    logic [K-1:0]  prev_le;
    logic [K-1:0]  ins;
    logic [K-1:0]  shf;
    logic          accept;
    logic          take;
    logic          last;

    // Valid slots are contiguous and sorted, so le is a thermometer code; the new
    // candidate lands at its single 1->0 edge, everything below that edge moves down.
    always_comb begin
        le = '0;
        for (int unsigned i = 0; i < K; i++) begin
            le[i] = sv[i] && (sd[i] <= io.in_dist);
        end
        prev_le = {le[K-2:0], 1'b1};
        ins     = ~le & prev_le;
        shf     = ~le & ~prev_le;
    end

    assign accept = io.in_valid && rdy_q;
    assign take   = vld_q && io.out_ready;
    assign last   = vld_q && (NW'(dcnt) == n - NW'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= COLLECT;
            sv    <= '0;
            n     <= '0;
            dcnt  <= '0;
            rdy_q <= 1'b0;
            vld_q <= 1'b0;
            for (int unsigned i = 0; i < K; i++) begin
                sd[i] <= '0;
                si[i] <= '0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    rdy_q <= 1'b1;
                    if (accept) begin
                        if (ins[0]) begin
                            sv[0] <= 1'b1;
                            sd[0] <= io.in_dist;
                            si[0] <= io.in_idx;
                        end
                        for (int unsigned i = 1; i < K; i++) begin
                            if (ins[i]) begin
                                sv[i] <= 1'b1;
                                sd[i] <= io.in_dist;
                                si[i] <= io.in_idx;
                            end else if (shf[i]) begin
                                sv[i] <= sv[i-1];
                                sd[i] <= sd[i-1];
                                si[i] <= si[i-1];
                            end
                        end
                        if (n != NW'(K)) begin
                            n <= n + NW'(1);
                        end
                        if (io.in_last) begin
                            state <= DRAIN;
                            rdy_q <= 1'b0;
                            vld_q <= 1'b1;
                            dcnt  <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (take) begin
                        if (last) begin
                            state <= COLLECT;
                            sv    <= '0;
                            n     <= '0;
                            dcnt  <= '0;
                            rdy_q <= 1'b1;
                            vld_q <= 1'b0;
                        end else begin
                            for (int unsigned i = 0; i < K - 1; i++) begin
                                sv[i] <= sv[i+1];
                                sd[i] <= sd[i+1];
                                si[i] <= si[i+1];
                            end
                            sv[K-1] <= 1'b0;
                            dcnt    <= dcnt + RW'(1);
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign io.in_ready  = rdy_q;
    assign io.out_valid = vld_q;
    assign io.out_dist  = sd[0];
    assign io.out_idx   = si[0];
    assign io.out_rank  = dcnt;
    assign io.out_last  = last;
endmodule

// File: tb/tb_topk_select.sv
// Directed bench for topk_select with K=4: ordering, short queries, ties, stalls,
// async reset mid-drain and back-to-back queries.
module tb_topk_select;
    localparam int K  = 4;
    localparam int DW = 16;
    localparam int IW = 12;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    topk_select_if #(.K(K), .DW(DW), .IW(IW)) io ();

    topk_select #(.K(K), .DW(DW), .IW(IW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .io   (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input int i, input logic l);
        chk("in_ready_at_push", 32'(io.in_ready), 32'd1);
        io.in_valid = 1'b1;
        io.in_dist  = DW'(d);
        io.in_idx   = IW'(i);
        io.in_last  = l;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.in_last  = 1'b0;
    endtask

    task automatic look(input string tag, input int d, input int i, input int r, input logic l);
        chk({tag, "_valid"}, 32'(io.out_valid), 32'd1);
        chk({tag, "_dist"},  32'(io.out_dist),  32'(d));
        chk({tag, "_idx"},   32'(io.out_idx),   32'(i));
        chk({tag, "_rank"},  32'(io.out_rank),  32'(r));
        chk({tag, "_last"},  32'(io.out_last),  32'(l));
    endtask

    task automatic pull(input string tag, input int d, input int i, input int r, input logic l);
        io.out_ready = 1'b1;
        @(negedge clk);
        look(tag, d, i, r, l);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"},  32'(io.in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(io.out_valid), 32'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rstn         = 1'b0;
        io.in_valid  = 1'b0;
        io.in_dist   = '0;
        io.in_idx    = '0;
        io.in_last   = 1'b0;
        io.out_ready = 1'b0;

        // reset state
        #3;
        chk("rst_in_ready",  32'(io.in_ready),  32'd0);
        chk("rst_out_valid", 32'(io.out_valid), 32'd0);
        chk("rst_out_last",  32'(io.out_last),  32'd0);
        chk("rst_out_rank",  32'(io.out_rank),  32'd0);
        chk("rst_out_dist",  32'(io.out_dist),  32'd0);
        chk("rst_out_idx",   32'(io.out_idx),   32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(io.in_ready), 32'd1);

        // five candidates, K=4: worst (9) dropped by the insert of 5
        push(9, 0, 1'b0);
        push(3, 1, 1'b0);
        push(7, 2, 1'b0);
        push(1, 3, 1'b0);
        push(5, 4, 1'b1);
        chk("q1_in_ready_drain", 32'(io.in_ready), 32'd0);
        pull("q1_r0", 1, 3, 0, 1'b0);
        pull("q1_r1", 3, 1, 1, 1'b0);
        pull("q1_r2", 5, 4, 2, 1'b0);
        pull("q1_r3", 7, 2, 3, 1'b1);
        idle_check("q1_done");

        // short query: exactly two results
        push(4, 0, 1'b0);
        push(2, 1, 1'b1);
        pull("q2_r0", 2, 1, 0, 1'b0);
        pull("q2_r1", 4, 0, 1, 1'b1);
        idle_check("q2_done");

        // ties keep arrival order
        push(5, 0, 1'b0);
        push(5, 1, 1'b0);
        push(5, 2, 1'b1);
        pull("q3_r0", 5, 0, 0, 1'b0);
        pull("q3_r1", 5, 1, 1, 1'b0);
        pull("q3_r2", 5, 2, 2, 1'b1);
        idle_check("q3_done");

        // stalls with a would-be best candidate held on the input during drain
        push(20, 5, 1'b0);
        push(10, 6, 1'b0);
        push(30, 7, 1'b1);
        io.in_valid = 1'b1;
        io.in_dist  = '0;
        io.in_idx   = IW'(99);
        io.in_last  = 1'b0;
        pull("q4_r0", 10, 6, 0, 1'b0);
        io.out_ready = 1'b0;
        @(negedge clk);
        look("q4_stall1", 20, 5, 1, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        look("q4_stall2", 20, 5, 1, 1'b0);
        @(posedge clk);
        #1;
        pull("q4_r1", 20, 5, 1, 1'b0);
        io.out_ready = 1'b1;
        @(negedge clk);
        look("q4_r2", 30, 7, 2, 1'b1);
        io.in_valid = 1'b0;
        @(posedge clk);
        #1;
        idle_check("q4_done");

        // async reset after two of four results
        push(40, 0, 1'b0);
        push(10, 1, 1'b0);
        push(30, 2, 1'b0);
        push(20, 3, 1'b1);
        pull("q5_r0", 10, 1, 0, 1'b0);
        pull("q5_r1", 20, 3, 1, 1'b0);
        rstn = 1'b0;
        #1;
        chk("q5_rst_out_valid", 32'(io.out_valid), 32'd0);
        chk("q5_rst_in_ready",  32'(io.in_ready),  32'd0);
        chk("q5_rst_out_rank",  32'(io.out_rank),  32'd0);
        chk("q5_rst_out_last",  32'(io.out_last),  32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("q5_post_rst_in_ready",  32'(io.in_ready),  32'd1);
        chk("q5_post_rst_out_valid", 32'(io.out_valid), 32'd0);
        push(8, 7, 1'b1);
        pull("q6_r0", 8, 7, 0, 1'b1);
        idle_check("q6_done");

        // back-to-back: next query's first candidate waits on the input
        push(6, 1, 1'b0);
        push(2, 2, 1'b1);
        io.in_valid = 1'b1;
        io.in_dist  = DW'(50);
        io.in_idx   = IW'(3);
        io.in_last  = 1'b0;
        pull("q7_r0", 2, 2, 0, 1'b0);
        pull("q7_r1", 6, 1, 1, 1'b1);
        @(negedge clk);
        chk("q8_in_ready_return", 32'(io.in_ready), 32'd1);
        @(posedge clk);
        #1;
        push(60, 4, 1'b1);
        pull("q8_r0", 50, 3, 0, 1'b0);
        pull("q8_r1", 60, 4, 1, 1'b1);
        idle_check("q8_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/topk_select.md
TOPK_SELECT -- requirements
Module: topk_select

Interface
REQ-001 Parameter K, default 8: number of nearest candidates retained per query; K>=2.
REQ-002 Parameter DW, default 16: distance width, unsigned.
REQ-003 Parameter IW, default 12: candidate index width.
REQ-004 clk  in  1  global clock, all state updates on rising edge.
REQ-005 rstn  in  1  reset, asynchronous and active-low; one clock domain only.
REQ-006 in_valid  in  1  input candidate present.
REQ-007 in_ready  out  1  block can accept a candidate this cycle.
REQ-008 in_dist  in  DW  candidate distance, lower is better.
REQ-009 in_idx  in  IW  candidate index, already latency-aligned to in_dist upstream.
REQ-010 in_last  in  1  marks final candidate of the current query.
REQ-011 out_valid  out  1  result entry present.
REQ-012 out_ready  in  1  consumer accepts result entry.
REQ-013 out_dist  out  DW  result distance.
REQ-014 out_idx  out  IW  result index.
REQ-015 out_rank  out  clog2(K)  rank of current result, 0 = nearest.
REQ-016 out_last  out  1  marks final result of the query.

Function
REQ-017 Two-state FSM: COLLECT (in_ready=1, out_valid=0) and DRAIN (in_ready=0, out_valid=1).
REQ-018 Storage: K slots {valid, dist, idx}, slot 0 best, kept sorted ascending by dist at all times.
REQ-019 Accept = in_valid && in_ready; one candidate per cycle, no bubbles.
REQ-020 On accept, insert position p = count of valid slots with dist <= in_dist; slots p..K-2 shift to p+1..K-1, old slot K-1 discarded; new candidate written to slot p.
REQ-021 p == K (all slots valid, all <= in_dist): candidate dropped, storage unchanged.
REQ-022 Ties: earlier-arriving candidate keeps the better rank.
REQ-023 Count register n saturates at K; increments on every accept in COLLECT.
REQ-024 Accept with in_last: FSM enters DRAIN the next cycle; out_valid asserts one cycle after last accept.
REQ-025 Number of results per query = min(K, candidates received); a query is always >=1 candidate.
REQ-026 DRAIN: out_dist/out_idx = slot 0, out_rank = drain counter, out_last = (drain counter == n-1).
REQ-027 On out_valid && out_ready: slots shift toward slot 0 by one, slot K-1 invalidated, drain counter increments.
REQ-028 Outputs held stable while out_valid && !out_ready.
REQ-029 Handshake with out_last: all slots invalidated, n and drain counter cleared, FSM returns to COLLECT next cycle; in_ready=1 that cycle.
REQ-030 in_valid during DRAIN is ignored (not accepted, no state change).
REQ-031 Distance compare unsigned, full DW bits; no arithmetic overflow possible.

Reset
REQ-032 rstn low: FSM = COLLECT, all slot valid bits 0, n = 0, drain counter = 0, immediately and independent of clk.
REQ-033 During reset: in_ready=1 only after rstn deasserts; out_valid=0, out_last=0, out_rank=0, out_dist=0, out_idx=0.
REQ-034 Reset mid-COLLECT or mid-DRAIN discards the query; no partial results emitted afterward.

Verification
REQ-035 K=4, dists 9,3,7,1,5(last), idx 0..4, out_ready=1 -> results (1,3),(3,1),(5,4),(7,2), ranks 0..3, out_last on rank 3.
REQ-036 K=4, two candidates (4,idx0),(2,idx1 last) -> exactly 2 results (2,1),(4,0), out_last on rank 1.
REQ-037 K=4, dists 5,5,5 idx 0,1,2 last -> results idx 0,1,2 in that order (tie rule).
REQ-038 out_ready toggled 1-0-0-1 during DRAIN -> outputs stable on stalled cycles, no result lost or duplicated; in_valid held high in DRAIN has no effect.
REQ-039 rstn pulsed low after 2nd result of 4 -> out_valid=0 asynchronously; next query of (8,idx7 last) returns only (8,7) with out_last.
REQ-040 Back-to-back queries: in_valid held high across boundary -> first candidate of query 2 accepted on cycle in_ready returns, results of query 1 unaffected.
